// File: rtl/rs_issue_scheduler.sv
// rs_issue_scheduler: dispatch allocation, age-ordered issue select and branch-tag tracking for one RS bank.
// Latency: grants, issue picks and clear strobes are combinational; age matrix and spec mask update at the clock edge.
// Backpressure: dispatch slots are refused in order when free entries run out or on a mispredict cycle; issue waits on fu_avail_i.
module rs_issue_scheduler #(
    parameter int RS_DEPTH    = 16,
    parameter int DISP_WIDTH  = 2,
    parameter int ISSUE_WIDTH = 2,
    parameter int FU_NUM      = 8
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic [DISP_WIDTH-1:0]                  disp_valid_i,
    input  logic [DISP_WIDTH-1:0]                  disp_spec_i,
    output logic [DISP_WIDTH-1:0]                  disp_grant_o,
    output logic [DISP_WIDTH*$clog2(RS_DEPTH)-1:0] disp_idx_o,
    output logic [RS_DEPTH-1:0]                    disp_enable_o,
    output logic [RS_DEPTH-1:0]                    br_mis_tag_o,
    input  logic [RS_DEPTH-1:0]                    entry_empty_i,
    input  logic [RS_DEPTH-1:0]                    entry_ready_i,
    input  logic [RS_DEPTH*$clog2(FU_NUM)-1:0]     entry_fu_type_i,
    input  logic [FU_NUM-1:0]                      fu_avail_i,
    output logic [RS_DEPTH-1:0]                    issue_o,
    output logic [ISSUE_WIDTH-1:0]                 issue_valid_o,
    output logic [ISSUE_WIDTH*$clog2(RS_DEPTH)-1:0] issue_idx_o,
    input  logic                                   br_resolve_i,
    input  logic                                   br_mispredict_i,
    output logic [RS_DEPTH-1:0]                    clear_br_tag_o,
    output logic [RS_DEPTH-1:0]                    clear_wrong_o,
    output logic [$clog2(RS_DEPTH):0]              free_count_o
);
    localparam int IDX_W = $clog2(RS_DEPTH);
    localparam int FU_W  = $clog2(FU_NUM);
    localparam int CNT_W = IDX_W + 1;

    // older_q[i][j] = 1 means entry i was allocated before entry j
    logic [RS_DEPTH-1:0][RS_DEPTH-1:0] older_q, older_nxt, older_col;
    logic [RS_DEPTH-1:0]               spec_q, spec_nxt;
    logic [RS_DEPTH-1:0][FU_W-1:0]     entry_fu;
    logic                              mispredict;

    logic [DISP_WIDTH-1:0]             alloc_vld;
    logic [DISP_WIDTH-1:0][IDX_W-1:0]  alloc_idx;
    logic [RS_DEPTH-1:0]               alloc_taken;
    logic                              alloc_chain, alloc_found;
    logic [IDX_W-1:0]                  alloc_pick;

    logic [RS_DEPTH-1:0]               cand, elig, picked;
    logic [FU_NUM-1:0]                 fu_claim;
    logic                              sel_found;
    logic [IDX_W-1:0]                  sel_idx;

    assign entry_fu   = entry_fu_type_i;
    assign mispredict = br_resolve_i & br_mispredict_i;

    assign clear_br_tag_o = (!reset && br_resolve_i && !br_mispredict_i) ? spec_q : '0;
    assign clear_wrong_o  = (!reset && mispredict) ? (spec_q & ~entry_empty_i) : '0;

    // Free-entry count straight from the entries' empty flags
    always_comb begin
        free_count_o = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            free_count_o = free_count_o + CNT_W'(entry_empty_i[i]);
        end
    end

    // In-order slot allocation: each granted slot takes the next lowest-index empty entry
    always_comb begin
        alloc_vld   = '0;
        alloc_idx   = '0;
        alloc_taken = '0;
        alloc_chain = 1'b1;
        alloc_found = 1'b0;
        alloc_pick  = '0;
        for (int k = 0; k < DISP_WIDTH; k++) begin
            alloc_found = 1'b0;
            alloc_pick  = '0;
            for (int e = 0; e < RS_DEPTH; e++) begin
                if (entry_empty_i[e] && !alloc_taken[e] && !alloc_found) begin
                    alloc_found = 1'b1;
                    alloc_pick  = IDX_W'(e);
                end
            end
            if (disp_valid_i[k]) begin
                if (alloc_chain && alloc_found && !mispredict) begin
                    alloc_vld[k]            = 1'b1;
                    alloc_idx[k]            = alloc_pick;
                    alloc_taken[alloc_pick] = 1'b1;
                end else begin
                    alloc_chain = 1'b0;
                end
            end
        end
    end

    // Dispatch outputs, silenced while reset is asserted
    always_comb begin
        disp_grant_o  = '0;
        disp_idx_o    = '0;
        disp_enable_o = '0;
        br_mis_tag_o  = '0;
        if (!reset) begin
            for (int k = 0; k < DISP_WIDTH; k++) begin
                if (alloc_vld[k]) begin
                    disp_grant_o[k]                  = 1'b1;
                    disp_idx_o[k*IDX_W +: IDX_W]     = alloc_idx[k];
                    disp_enable_o[alloc_idx[k]]      = 1'b1;
                    br_mis_tag_o[alloc_idx[k]]       = disp_spec_i[k];
                end
            end
        end
    end

    // Transpose so each entry sees which entries are older than it
    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            for (int j = 0; j < RS_DEPTH; j++) begin
                older_col[i][j] = older_q[j][i];
            end
        end
    end

    // Issue select: per slot, the oldest eligible candidate on an unclaimed FU type
    always_comb begin
        issue_o       = '0;
        issue_valid_o = '0;
        issue_idx_o   = '0;
        picked        = '0;
        fu_claim      = '0;
        elig          = '0;
        sel_found     = 1'b0;
        sel_idx       = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            cand[i] = entry_ready_i[i] & ~entry_empty_i[i] & fu_avail_i[entry_fu[i]]
                      & ~(mispredict & spec_q[i]);
        end
        if (!reset) begin
            for (int s = 0; s < ISSUE_WIDTH; s++) begin
                elig = cand & ~picked;
                for (int i = 0; i < RS_DEPTH; i++) begin
                    if (fu_claim[entry_fu[i]]) elig[i] = 1'b0;
                end
                sel_found = 1'b0;
                sel_idx   = '0;
                for (int i = 0; i < RS_DEPTH; i++) begin
                    if (elig[i] && ((elig & older_col[i]) == '0) && !sel_found) begin
                        sel_found = 1'b1;
                        sel_idx   = IDX_W'(i);
                    end
                end
                if (sel_found) begin
                    picked[sel_idx]                 = 1'b1;
                    fu_claim[entry_fu[sel_idx]]     = 1'b1;
                    issue_valid_o[s]                = 1'b1;
                    issue_idx_o[s*IDX_W +: IDX_W]   = sel_idx;
                end
            end
            issue_o = picked;
        end
    end

    // Next age matrix and spec mask: new entries are younger than every surviving entry
    always_comb begin
        older_nxt = older_q;
        spec_nxt  = br_resolve_i ? '0 : spec_q;
        for (int k = 0; k < DISP_WIDTH; k++) begin
            if (alloc_vld[k]) begin
                for (int j = 0; j < RS_DEPTH; j++) begin
                    older_nxt[j][alloc_idx[k]] = ~entry_empty_i[j] & ~issue_o[j];
                    older_nxt[alloc_idx[k]][j] = 1'b0;
                end
                for (int m = 0; m < DISP_WIDTH; m++) begin
                    if (m < k && alloc_vld[m]) older_nxt[alloc_idx[m]][alloc_idx[k]] = 1'b1;
                end
                spec_nxt[alloc_idx[k]] = disp_spec_i[k];
            end
        end
    end

    // State registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            older_q <= '0;
            spec_q  <= '0;
        end else begin
            older_q <= older_nxt;
            spec_q  <= spec_nxt;
        end
    end

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// tb_rs_issue_scheduler: random and directed stimulus against a sequence-number reference model of the RS bank.
// Inputs are driven on the falling edge and outputs sampled 1 time unit later; the model advances after each rising edge.
// Entries are modelled in the bench: dispatched entries fill, issued or flushed entries empty, ready bits wake randomly.
module tb_rs_issue_scheduler;
    localparam int D  = 16;
    localparam int DW = 2;
    localparam int IW = 2;
    localparam int FN = 8;
    localparam int XW = 4;
    localparam int FW = 3;
    localparam int CW = XW + 1;

    logic              clock = 1'b0;
    logic              reset;
    logic [DW-1:0]     disp_valid_i, disp_spec_i, disp_grant_o;
    logic [DW*XW-1:0]  disp_idx_o;
    logic [D-1:0]      disp_enable_o, br_mis_tag_o, entry_empty_i, entry_ready_i;
    logic [D*FW-1:0]   entry_fu_type_i;
    logic [FN-1:0]     fu_avail_i;
    logic [D-1:0]      issue_o, clear_br_tag_o, clear_wrong_o;
    logic [IW-1:0]     issue_valid_o;
    logic [IW*XW-1:0]  issue_idx_o;
    logic              br_resolve_i, br_mispredict_i;
    logic [CW-1:0]     free_count_o;

    rs_issue_scheduler #(.RS_DEPTH(D), .DISP_WIDTH(DW), .ISSUE_WIDTH(IW), .FU_NUM(FN)) dut (
        .clock(clock), .reset(reset),
        .disp_valid_i(disp_valid_i), .disp_spec_i(disp_spec_i),
        .disp_grant_o(disp_grant_o), .disp_idx_o(disp_idx_o),
        .disp_enable_o(disp_enable_o), .br_mis_tag_o(br_mis_tag_o),
        .entry_empty_i(entry_empty_i), .entry_ready_i(entry_ready_i),
        .entry_fu_type_i(entry_fu_type_i), .fu_avail_i(fu_avail_i),
        .issue_o(issue_o), .issue_valid_o(issue_valid_o), .issue_idx_o(issue_idx_o),
        .br_resolve_i(br_resolve_i), .br_mispredict_i(br_mispredict_i),
        .clear_br_tag_o(clear_br_tag_o), .clear_wrong_o(clear_wrong_o),
        .free_count_o(free_count_o)
    );

    always #5 clock = ~clock;

    // Reference bank: occupancy, readiness, FU type, speculative flag, allocation sequence number
    bit occ[D];
    bit rdy[D];
    int fu[D];
    bit spc[D];
    int seq[D];
    int seq_ctr;

    int n_tests;
    int n_fail;

    logic [DW-1:0]    e_grant;
    logic [DW*XW-1:0] e_didx;
    logic [D-1:0]     e_en, e_tag, e_issue, e_cbt, e_cw;
    logic [IW-1:0]    e_ivld;
    logic [IW*XW-1:0] e_iidx;
    logic [CW-1:0]    e_free;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic drive_bank();
        for (int i = 0; i < D; i++) begin
            entry_empty_i[i]            = !occ[i];
            entry_ready_i[i]            = occ[i] && rdy[i];
            entry_fu_type_i[i*FW +: FW] = FW'(fu[i]);
        end
    endtask

    task automatic compute_exp();
        int  fl[$];
        int  ng;
        bit  chain;
        bit  mis;
        bit  picked[D];
        bit  claimed[FN];
        int  best;
        mis = br_resolve_i && br_mispredict_i;
        e_grant = '0; e_didx = '0; e_en = '0; e_tag = '0;
        e_issue = '0; e_ivld = '0; e_iidx = '0; e_cbt = '0; e_cw = '0;
        for (int i = 0; i < D; i++) begin
            picked[i] = 1'b0;
            if (!occ[i]) fl.push_back(i);
        end
        for (int f = 0; f < FN; f++) claimed[f] = 1'b0;
        e_free = CW'(fl.size());
        ng = 0;
        chain = 1'b1;
        for (int k = 0; k < DW; k++) begin
            if (disp_valid_i[k]) begin
                if (chain && !mis && fl.size() > ng) begin
                    e_grant[k]           = 1'b1;
                    e_didx[k*XW +: XW]   = XW'(fl[ng]);
                    e_en[fl[ng]]         = 1'b1;
                    e_tag[fl[ng]]        = disp_spec_i[k];
                    ng++;
                end else begin
                    chain = 1'b0;
                end
            end
        end
        for (int s = 0; s < IW; s++) begin
            best = -1;
            for (int i = 0; i < D; i++) begin
                if (occ[i] && rdy[i] && fu_avail_i[fu[i]] && !(mis && spc[i]) &&
                    !picked[i] && !claimed[fu[i]]) begin
                    if (best < 0 || seq[i] < seq[best]) best = i;
                end
            end
            if (best >= 0) begin
                picked[best]        = 1'b1;
                claimed[fu[best]]   = 1'b1;
                e_ivld[s]           = 1'b1;
                e_iidx[s*XW +: XW]  = XW'(best);
                e_issue[best]       = 1'b1;
            end
        end
        for (int i = 0; i < D; i++) begin
            if (br_resolve_i && !mis) e_cbt[i] = spc[i];
            if (mis)                  e_cw[i]  = spc[i] && occ[i];
        end
    endtask

    task automatic check_all();
        chk("grant",     64'(disp_grant_o),   64'(e_grant));
        chk("disp_idx",  64'(disp_idx_o),     64'(e_didx));
        chk("disp_en",   64'(disp_enable_o),  64'(e_en));
        chk("mis_tag",   64'(br_mis_tag_o),   64'(e_tag));
        chk("issue",     64'(issue_o),        64'(e_issue));
        chk("issue_vld", 64'(issue_valid_o),  64'(e_ivld));
        chk("issue_idx", 64'(issue_idx_o),    64'(e_iidx));
        chk("clr_tag",   64'(clear_br_tag_o), 64'(e_cbt));
        chk("clr_wrong", 64'(clear_wrong_o),  64'(e_cw));
        chk("free_cnt",  64'(free_count_o),   64'(e_free));
    endtask

    task automatic cycle_check();
        drive_bank();
        #1;
        compute_exp();
        check_all();
    endtask

    // Advance the model past the rising edge using the picks computed before it
    task automatic cycle_commit(input int pct);
        int e;
        bit mis;
        @(posedge clock);
        #1;
        mis = br_resolve_i && br_mispredict_i;
        for (int i = 0; i < D; i++) begin
            if (e_issue[i]) begin occ[i] = 1'b0; rdy[i] = 1'b0; end
            if (mis && spc[i] && occ[i]) begin occ[i] = 1'b0; rdy[i] = 1'b0; end
        end
        if (br_resolve_i) for (int i = 0; i < D; i++) spc[i] = 1'b0;
        for (int i = 0; i < D; i++) begin
            if (occ[i] && !rdy[i] && $urandom_range(99) < pct) rdy[i] = 1'b1;
        end
        for (int k = 0; k < DW; k++) begin
            if (e_grant[k]) begin
                e      = int'(e_didx[k*XW +: XW]);
                occ[e] = 1'b1;
                rdy[e] = ($urandom_range(99) < pct);
                fu[e]  = $urandom_range(FN-1);
                spc[e] = disp_spec_i[k];
                seq[e] = seq_ctr;
                seq_ctr++;
            end
        end
    endtask

    task automatic step(input int pct);
        @(negedge clock);
        disp_valid_i    = DW'($urandom);
        disp_spec_i     = DW'($urandom);
        fu_avail_i      = FN'($urandom | $urandom);
        br_resolve_i    = ($urandom_range(11) == 0);
        br_mispredict_i = 1'($urandom_range(1));
        cycle_check();
        cycle_commit(pct);
    endtask

    task automatic set_in(input logic [DW-1:0] v, input logic [DW-1:0] sp, input logic [FN-1:0] fa,
                          input logic res, input logic mp);
        disp_valid_i = v; disp_spec_i = sp; fu_avail_i = fa; br_resolve_i = res; br_mispredict_i = mp;
    endtask

    task automatic model_reset();
        for (int i = 0; i < D; i++) begin
            occ[i] = 1'b0; rdy[i] = 1'b0; fu[i] = 0; spc[i] = 1'b0; seq[i] = 0;
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0; seq_ctr = 0;
        model_reset();
        reset = 1'b1;
        set_in(2'b11, 2'b00, 8'hFF, 1'b0, 1'b0);
        drive_bank();
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_grant", 64'(disp_grant_o), 64'd0);
        chk("rst_free",  64'(free_count_o), 64'd16);
        reset = 1'b0;

        // Two non-speculative dispatches into an empty bank
        @(negedge clock);
        set_in(2'b11, 2'b00, 8'h00, 1'b0, 1'b0);
        cycle_check();
        chk("tp_grant",  64'(disp_grant_o),  64'h3);
        chk("tp_idx",    64'(disp_idx_o),    64'h10);
        chk("tp_en",     64'(disp_enable_o), 64'h0003);
        cycle_commit(0);

        // Same FU type: the older entry goes first, the other the cycle after
        rdy[0] = 1'b1; rdy[1] = 1'b1; fu[0] = 2; fu[1] = 2;
        @(negedge clock);
        set_in(2'b00, 2'b00, 8'h00, 1'b0, 1'b0);
        cycle_check();
        chk("no_fu_issue", 64'(issue_o), 64'h0);
        cycle_commit(0);
        @(negedge clock);
        set_in(2'b00, 2'b00, 8'h04, 1'b0, 1'b0);
        cycle_check();
        chk("age_vld", 64'(issue_valid_o), 64'h1);
        chk("age_iss", 64'(issue_o),       64'h1);
        cycle_commit(0);
        @(negedge clock);
        cycle_check();
        chk("age_next", 64'(issue_o), 64'h2);
        cycle_commit(0);

        // Two speculative then two non-speculative entries, then a mispredict
        @(negedge clock);
        set_in(2'b11, 2'b11, 8'h00, 1'b0, 1'b0);
        cycle_check();
        cycle_commit(0);
        @(negedge clock);
        set_in(2'b11, 2'b00, 8'h00, 1'b0, 1'b0);
        cycle_check();
        cycle_commit(0);
        for (int i = 0; i < 4; i++) begin rdy[i] = 1'b1; fu[i] = i; end
        @(negedge clock);
        set_in(2'b11, 2'b00, 8'hFF, 1'b1, 1'b1);
        cycle_check();
        chk("mp_wrong", 64'(clear_wrong_o), 64'h0003);
        chk("mp_grant", 64'(disp_grant_o),  64'h0);
        chk("mp_issue", 64'(issue_o),       64'h000C);
        chk("mp_idx",   64'(issue_idx_o),   64'h32);
        cycle_commit(0);

        // Correct resolve alongside a new speculative dispatch
        @(negedge clock);
        set_in(2'b01, 2'b01, 8'h00, 1'b0, 1'b0);
        cycle_check();
        cycle_commit(0);
        @(negedge clock);
        set_in(2'b01, 2'b01, 8'h00, 1'b1, 1'b0);
        cycle_check();
        chk("ok_tag", 64'(clear_br_tag_o), 64'h0001);
        cycle_commit(0);
        @(negedge clock);
        set_in(2'b00, 2'b00, 8'h00, 1'b1, 1'b1);
        cycle_check();
        chk("ok_after", 64'(clear_wrong_o), 64'h0002);
        cycle_commit(0);

        // Random traffic: fill phase, drain phase, mixed phase
        for (int c = 0; c < 900; c++) begin
            step(c < 300 ? 5 : (c < 600 ? 70 : 30));
        end

        // Reset asserted mid-dispatch
        @(negedge clock);
        set_in(2'b11, 2'b01, 8'hFF, 1'b1, 1'b0);
        cycle_check();
        reset = 1'b1;
        #1;
        chk("arst_grant", 64'(disp_grant_o),   64'h0);
        chk("arst_en",    64'(disp_enable_o),  64'h0);
        chk("arst_tag",   64'(br_mis_tag_o),   64'h0);
        chk("arst_issue", 64'(issue_o),        64'h0);
        chk("arst_ivld",  64'(issue_valid_o),  64'h0);
        chk("arst_ctag",  64'(clear_br_tag_o), 64'h0);
        chk("arst_free",  64'(free_count_o),   64'(e_free));
        model_reset();
        drive_bank();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 100; c++) step(40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rs_issue_scheduler.md
Name: rs_issue_scheduler

Overview:
- Control block for an RS bank of RS_DEPTH rs_single_entry instances.
- Allocates empty entries to dispatch slots and tracks relative age with a registered age matrix.
- Selects up to ISSUE_WIDTH oldest ready entries per cycle, one per available FU type, and drives per-entry issue strobes.
- Tracks which entries are speculative under the unresolved branch; on resolve it drives clear_br_tag or clear_wrong to those entries.

Parameters:
RS_DEPTH, 16, number of RS entries
DISP_WIDTH, 2, dispatch slots per cycle
ISSUE_WIDTH, 2, issue grants per cycle
FU_NUM, 8, number of FU types; each FU type accepts at most one op per cycle

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
disp_valid_i  in  DISP_WIDTH  dispatch request per slot
disp_spec_i  in  DISP_WIDTH  slot instruction is younger than the unresolved branch
disp_grant_o  out  DISP_WIDTH  slot accepted this cycle
disp_idx_o  out  DISP_WIDTH*$clog2(RS_DEPTH)  entry index assigned to each granted slot
disp_enable_o  out  RS_DEPTH  per-entry dispatch enable
br_mis_tag_o  out  RS_DEPTH  per-entry speculative tag, loaded with dispatch
entry_empty_i  in  RS_DEPTH  empty_o from each entry
entry_ready_i  in  RS_DEPTH  ready_o from each entry
entry_fu_type_i  in  RS_DEPTH*$clog2(FU_NUM)  fu_type_o from each entry
fu_avail_i  in  FU_NUM  FU type can accept an op this cycle
issue_o  out  RS_DEPTH  per-entry issue strobe
issue_valid_o  out  ISSUE_WIDTH  issue slot valid
issue_idx_o  out  ISSUE_WIDTH*$clog2(RS_DEPTH)  entry index per issue slot
br_resolve_i  in  1  unresolved branch resolved this cycle
br_mispredict_i  in  1  qualifies br_resolve_i: resolved as mispredicted
clear_br_tag_o  out  RS_DEPTH  per-entry tag clear (correct prediction)
clear_wrong_o  out  RS_DEPTH  per-entry flush (mispredict)
free_count_o  out  $clog2(RS_DEPTH)+1  popcount(entry_empty_i)

Behaviour:
- Reset (asynchronous): age matrix and spec mask are cleared. All grant, issue and clear outputs are 0 while reset is high. free_count_o is combinational and follows entry_empty_i.
- State: older[i][j] is RS_DEPTH x RS_DEPTH; a 1 means entry i is older than entry j. spec[RS_DEPTH] holds the speculative mask.
- Dispatch allocation (combinational, same cycle):
  - Slot k is granted iff disp_valid_i[k], all valid lower slots are granted, free entries exceed grants to lower slots, and it is not a mispredict cycle.
  - Slot k receives the k-th lowest-index empty entry.
  - disp_enable_o is one-hot per granted entry; br_mis_tag_o[e] = disp_spec_i[k] for the assigned entry e.
- Age update at the posedge, for allocated entry e:
  - older[j][e] = 1 for every non-empty j not being issued.
  - older[e][j] = 0.
  - Same-cycle allocations: a lower slot is older than a higher slot.
  - spec[e] <= disp_spec_i[k].
- Issue selection (combinational):
  - Candidate = entry_ready_i & ~entry_empty_i & fu_avail_i[fu_type]; on a mispredict cycle, spec entries are excluded.
  - Slot 0 takes the oldest candidate, i.e. no other candidate is older. Slot s takes the oldest candidate not already picked and whose FU type is not claimed by a lower slot.
  - Ties (no age relation, post-reset) resolve to the lowest index.
  - issue_o is the OR of the picks. Zero-latency: the entry empties at the next edge, so there is no re-issue.
  - Unused slots drive issue_valid_o=0 and issue_idx_o=0.
- Branch resolve:
  - br_resolve_i & ~br_mispredict_i: clear_br_tag_o = spec; spec <= 0 at the edge.
  - br_resolve_i & br_mispredict_i: clear_wrong_o = spec & ~entry_empty_i; spec <= 0. All dispatch grants are forced to 0 this cycle. Non-spec ready entries may still issue.
- Simultaneous dispatch with correct resolve: the newly allocated entry keeps its disp_spec_i (it refers to the next branch). Clear strobes apply only to entries in spec before the edge.
- Full: free_count_o=0 gives disp_grant_o=0. Empty: no issue_valid_o.
- Reset mid-operation clears all state immediately, independent of the clock.

Test Plan:
- Reset then 2 dispatches (spec=0) into an empty bank -> grant=2'b11, idx0=0, idx1=1; disp_enable_o=16'h0003 for one cycle.
- Entries 3 (older) and 5 both ready, same FU type 2, fu_avail_i[2]=1 -> issue_idx_o[0]=3, issue_valid_o=2'b01; next cycle 5 issues.
- 15 entries occupied, 2 slots valid -> disp_grant_o=2'b01, free_count_o=1; then 0 free -> grant=0.
- Entries 2,4,6 spec, mispredict pulse -> clear_wrong_o=16'h0054, disp_grant_o=0, ready spec entry 4 not issued, non-spec ready entry 1 issues.
- Correct resolve with spec entries {7} plus simultaneous spec dispatch into 8 -> clear_br_tag_o=16'h0080, spec mask afterwards = {8}.
- fu_avail_i=0 for all types with ready entries -> issue_o=0; assert reset mid-dispatch -> all outputs 0 asynchronously.
